// File: rtl/famikey_matrix_scanner_if.sv
// Famicom keyboard scanner bus: PS/2 events, keymap port and $4016/$4017.
interface famikey_matrix_scanner_if #(
    parameter int ROW_BITS = 4
);
    logic                key_strobe;
    logic                key_pressed;
    logic                key_extended;
    logic [7:0]          key_code;
    logic                map_we;
    logic [8:0]          map_addr;
    logic [ROW_BITS+3:0] map_data;
    logic                release_all;
    logic [2:0]          reg_4016;
    logic [3:0]          reg_4017;
    logic [ROW_BITS-1:0] cur_row;

    modport master (
        output key_strobe, key_pressed, key_extended, key_code,
        output map_we, map_addr, map_data, release_all, reg_4016,
        input  reg_4017, cur_row
    );

    modport slave (
        input  key_strobe, key_pressed, key_extended, key_code,
        input  map_we, map_addr, map_data, release_all, reg_4016,
        output reg_4017, cur_row
    );
endinterface

// File: rtl/famikey_matrix_scanner.sv
// Famicom keyboard matrix: PS/2 events through a keymap RAM into a
// NUM_ROWS x 8 matrix, read back by the CPU over $4016/$4017.
module famikey_matrix_scanner #(
    parameter int NUM_ROWS = 9,
    parameter int ROW_BITS = 4,
    parameter bit STICKY   = 1'b1
) (
    input logic clk,
    input logic reset,
    famikey_matrix_scanner_if.slave bus
);
    localparam int NR = 2 ** ROW_BITS;
    localparam logic [ROW_BITS-1:0] LP_ROWS = ROW_BITS'(NUM_ROWS);

    logic [ROW_BITS+3:0] r_map [512];
    logic [ROW_BITS+3:0] r_s0_entry;
    logic                r_s0_pressed;
    logic                r_s0_vld;
    logic [7:0]          r_matrix [NR];
    logic [7:0]          r_pend [NR];
    logic [NR-1:0]       r_seen;
    logic [ROW_BITS-1:0] r_cur_row;
    logic                r_last_col;
    logic [3:0]          r_4017;

    logic                w_entry_vld;
    logic [ROW_BITS-1:0] w_ev_row;
    logic [2:0]          w_ev_bit;
    logic                w_s1_hit;
    logic                w_col_fall;
    logic                w_leave;
    logic                w_seen_eff;
    logic [ROW_BITS-1:0] w_next_row;
    logic [7:0]          w_row_data;
    logic [3:0]          w_nibble;

    assign w_entry_vld = r_s0_entry[ROW_BITS+3];
    assign w_ev_row    = r_s0_entry[ROW_BITS+2:3];
    assign w_ev_bit    = r_s0_entry[2:0];
    assign w_s1_hit    = r_s0_vld && w_entry_vld && (w_ev_row < LP_ROWS);

    assign w_col_fall = r_last_col && !bus.reg_4016[1];
    assign w_leave    = (bus.reg_4016[0] || w_col_fall)
                        && (r_cur_row < LP_ROWS);

    // A row being left in this very cycle already counts as scanned.
    assign w_seen_eff = r_seen[w_ev_row]
                        || (w_leave && (r_cur_row == w_ev_row));

    always_comb begin
        w_next_row = r_cur_row;
        if (w_col_fall) begin
            w_next_row = (r_cur_row == LP_ROWS) ? '0
                         : r_cur_row + ROW_BITS'(1);
        end
        if (bus.reg_4016[0]) begin
            w_next_row = '0;
        end
    end

    // The dummy row past the last real one always reads as no keys.
    assign w_row_data = (r_cur_row < LP_ROWS) ? r_matrix[r_cur_row]
                        : 8'h00;
    assign w_nibble   = bus.reg_4016[1] ? w_row_data[3:0]
                        : w_row_data[7:4];

    always_ff @(posedge clk) begin
        if (bus.map_we) begin
            r_map[bus.map_addr] <= bus.map_data;
        end
        r_s0_entry   <= r_map[{bus.key_extended, bus.key_code}];
        r_s0_pressed <= bus.key_pressed;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s0_vld   <= 1'b0;
            r_cur_row  <= '0;
            r_last_col <= 1'b0;
            r_4017     <= 4'h0;
            r_seen     <= '0;
            for (int i = 0; i < NR; i++) begin
                r_matrix[i] <= 8'h00;
                r_pend[i]   <= 8'h00;
            end
        end else begin
            r_s0_vld   <= bus.key_strobe;
            r_last_col <= bus.reg_4016[1];
            r_cur_row  <= w_next_row;
            r_4017     <= bus.reg_4016[2] ? ~w_nibble : 4'h0;

            if (w_leave) begin
                r_seen[r_cur_row]   <= 1'b1;
                r_matrix[r_cur_row] <= r_matrix[r_cur_row]
                                       & ~r_pend[r_cur_row];
                r_pend[r_cur_row]   <= 8'h00;
            end

            if (w_s1_hit) begin
                if (r_s0_pressed) begin
                    r_matrix[w_ev_row][w_ev_bit] <= 1'b1;
                    r_pend[w_ev_row][w_ev_bit]   <= 1'b0;
                    r_seen[w_ev_row]             <= 1'b0;
                end else if (!STICKY || w_seen_eff) begin
                    r_matrix[w_ev_row][w_ev_bit] <= 1'b0;
                    r_pend[w_ev_row][w_ev_bit]   <= 1'b0;
                end else begin
                    r_pend[w_ev_row][w_ev_bit]   <= 1'b1;
                end
            end

            if (bus.release_all) begin
                for (int i = 0; i < NR; i++) begin
                    r_matrix[i] <= 8'h00;
                    r_pend[i]   <= 8'h00;
                end
            end
        end
    end

    assign bus.reg_4017 = r_4017;
    assign bus.cur_row  = r_cur_row;
endmodule

// File: tb/tb_famikey_matrix_scanner.sv
// Bench for famikey_matrix_scanner: directed vectors, corner sequences and
// a randomized run against a queue-based event model.
module tb_famikey_matrix_scanner;
    localparam logic [3:0] NR4 = 4'd9;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    famikey_matrix_scanner_if #(.ROW_BITS(4)) if1 ();
    famikey_matrix_scanner_if #(.ROW_BITS(4)) if0 ();

    famikey_matrix_scanner #(
        .NUM_ROWS(9), .ROW_BITS(4), .STICKY(1'b1)
    ) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

    famikey_matrix_scanner #(
        .NUM_ROWS(9), .ROW_BITS(4), .STICKY(1'b0)
    ) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));

    assign if0.key_strobe   = if1.key_strobe;
    assign if0.key_pressed  = if1.key_pressed;
    assign if0.key_extended = if1.key_extended;
    assign if0.key_code     = if1.key_code;
    assign if0.map_we       = if1.map_we;
    assign if0.map_addr     = if1.map_addr;
    assign if0.map_data     = if1.map_data;
    assign if0.release_all  = if1.release_all;
    assign if0.reg_4016     = if1.reg_4016;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model (sticky behaviour): key state per row, events in a queue.
    typedef struct packed {
        logic       p;
        logic [7:0] e;
    } ev_t;
    logic [7:0] m_map [512];
    logic [7:0] m_mat [16];
    logic [7:0] m_pend [16];
    logic       m_seen [16];
    logic [3:0] m_row = 4'd0;
    logic       m_last = 1'b0;
    logic [3:0] m_out = 4'd0;
    ev_t        evq [$];

    typedef struct {
        logic [2:0] r;
        logic [3:0] row;
        logic [3:0] out;
    } vec_t;
    vec_t vt [25];

    task automatic chk(input string nm, input logic [3:0] act,
                       input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        logic [7:0] rowv;
        logic [3:0] nib;
        logic [3:0] n_out;
        logic [3:0] n_row;
        logic       fall;
        logic       lv;
        ev_t        ev;
        logic [3:0] er;
        logic [2:0] eb;
        rowv  = (m_row < NR4) ? m_mat[m_row] : 8'h00;
        nib   = if1.reg_4016[1] ? rowv[3:0] : rowv[7:4];
        n_out = if1.reg_4016[2] ? ~nib : 4'h0;
        fall  = m_last && !if1.reg_4016[1];
        lv    = fall || if1.reg_4016[0];
        n_row = m_row;
        if (fall) n_row = (m_row == NR4) ? 4'd0 : m_row + 4'd1;
        if (if1.reg_4016[0]) n_row = 4'd0;
        if (lv && m_row < NR4) begin
            m_seen[m_row] = 1'b1;
            m_mat[m_row]  = m_mat[m_row] & ~m_pend[m_row];
            m_pend[m_row] = 8'h00;
        end
        if (evq.size() != 0) begin
            ev = evq.pop_front();
            er = ev.e[6:3];
            eb = ev.e[2:0];
            if (ev.e[7] && er < NR4) begin
                if (ev.p) begin
                    m_mat[er][eb]  = 1'b1;
                    m_pend[er][eb] = 1'b0;
                    m_seen[er]     = 1'b0;
                end else if (m_seen[er]) begin
                    m_mat[er][eb]  = 1'b0;
                    m_pend[er][eb] = 1'b0;
                end else begin
                    m_pend[er][eb] = 1'b1;
                end
            end
        end
        if (if1.release_all) begin
            for (int i = 0; i < 16; i++) begin
                m_mat[i]  = 8'h00;
                m_pend[i] = 8'h00;
            end
        end
        if (if1.key_strobe) begin
            ev = {if1.key_pressed,
                  m_map[{if1.key_extended, if1.key_code}]};
            evq.push_back(ev);
        end
        if (if1.map_we) m_map[if1.map_addr] = if1.map_data;
        m_last = if1.reg_4016[1];
        m_row  = n_row;
        m_out  = n_out;
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_mat[i]  = 8'h00;
                m_pend[i] = 8'h00;
                m_seen[i] = 1'b0;
            end
            m_last = 1'b0;
            m_row  = 4'd0;
            m_out  = 4'd0;
            evq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [8:0] a, input logic p);
        if1.key_strobe   = 1'b1;
        if1.key_extended = a[8];
        if1.key_code     = a[7:0];
        if1.key_pressed  = p;
        tick();
        if1.key_strobe   = 1'b0;
    endtask

    task automatic mapw(input logic [8:0] a, input logic [7:0] d);
        if1.map_we   = 1'b1;
        if1.map_addr = a;
        if1.map_data = d;
        tick();
        if1.map_we   = 1'b0;
    endtask

    task automatic walk(input int n);
        for (int i = 0; i < n; i++) begin
            if1.reg_4016 = 3'b110;
            tick();
            if1.reg_4016 = 3'b100;
            tick();
        end
        tick();
    endtask

    task automatic goto_row(input int n);
        if1.reg_4016 = 3'b101;
        tick();
        if1.reg_4016 = 3'b100;
        tick();
        walk(n);
    endtask

    task automatic scan_all_clear(input string nm);
        goto_row(0);
        for (int r = 0; r < 9; r++) begin
            if1.reg_4016 = 3'b110;
            tick();
            chk({nm, "_lo"}, if1.reg_4017, 4'hF);
            if1.reg_4016 = 3'b100;
            tick();
            chk({nm, "_hi"}, if1.reg_4017, 4'hF);
        end
    endtask

    initial begin
        logic [8:0] ra [16];
        vt[0] = '{3'b101, 4'd0, 4'hF};
        for (int k = 1; k <= 10; k++) begin
            vt[2*k-1] = '{3'b110, 4'(k-1), (k == 1) ? 4'hE : 4'hF};
            vt[2*k]   = '{3'b100, 4'(k % 10), 4'hF};
        end
        vt[21] = '{3'b110, 4'd0, 4'hE};
        vt[22] = '{3'b010, 4'd0, 4'h0};
        vt[23] = '{3'b000, 4'd1, 4'h0};
        vt[24] = '{3'b010, 4'd1, 4'h0};

        for (int i = 0; i < 16; i++) begin
            m_mat[i] = 8'h00; m_pend[i] = 8'h00; m_seen[i] = 1'b0;
        end
        if1.key_strobe = 1'b0; if1.key_pressed = 1'b0;
        if1.key_extended = 1'b0; if1.key_code = 8'h00;
        if1.map_we = 1'b0; if1.map_addr = 9'h0; if1.map_data = 8'h00;
        if1.release_all = 1'b0; if1.reg_4016 = 3'b000;

        reset = 1'b1;
        tick();
        chk("reset_4017", if1.reg_4017, 4'h0);
        chk("reset_row", if1.cur_row, 4'd0);
        reset = 1'b0;

        for (int a = 0; a < 512; a++) mapw(9'(a), 8'h00);
        mapw(9'h01C, 8'hB7);
        mapw(9'h015, 8'h80);

        // Basic press/release latency on row 6
        goto_row(6);
        chk("goto6_row", if1.cur_row, 4'd6);
        chk("idle_row6", if1.reg_4017, 4'hF);
        strobe(9'h01C, 1'b1);
        tick();
        chk("press_lat2", if1.reg_4017, 4'hF);
        tick();
        chk("press_lat3", if1.reg_4017, 4'h7);
        chk("press_lat3_s0", if0.reg_4017, 4'h7);
        strobe(9'h01C, 1'b0);
        tick();
        tick();
        chk("release_s0", if0.reg_4017, 4'hF);
        chk("release_pend", if1.reg_4017, 4'h7);
        goto_row(6);
        chk("release_after_scan", if1.reg_4017, 4'hF);

        // Short tap while another row is selected
        goto_row(2);
        strobe(9'h01C, 1'b1);
        strobe(9'h01C, 1'b0);
        tick(); tick(); tick();
        walk(4);
        chk("tap_row", if1.cur_row, 4'd6);
        chk("tap_sticky", if1.reg_4017, 4'h7);
        chk("tap_nosticky", if0.reg_4017, 4'hF);
        walk(1);
        chk("tap_leave_row", if1.cur_row, 4'd7);
        goto_row(6);
        chk("tap_cleared", if1.reg_4017, 4'hF);

        // Row walk table with one key held in row 0
        if1.release_all = 1'b1;
        tick();
        if1.release_all = 1'b0;
        strobe(9'h015, 1'b1);
        tick(); tick();
        for (int v = 0; v < 25; v++) begin
            if1.reg_4016 = vt[v].r;
            tick();
            chk($sformatf("walk%0d_row", v), if1.cur_row, vt[v].row);
            chk($sformatf("walk%0d_out", v), if1.reg_4017, vt[v].out);
        end

        // Keymap write racing a lookup of the same address
        goto_row(0);
        if1.map_we = 1'b1; if1.map_addr = 9'h01C; if1.map_data = 8'h87;
        strobe(9'h01C, 1'b1);
        if1.map_we = 1'b0;
        tick(); tick();
        chk("race_row0", if1.reg_4017, 4'hF);
        goto_row(6);
        chk("race_row6", if1.reg_4017, 4'h7);
        strobe(9'h01C, 1'b1);
        tick(); tick();
        goto_row(0);
        chk("race_next", if1.reg_4017, 4'h7);

        // Invalid and out-of-range entries leave the matrix alone
        if1.release_all = 1'b1;
        tick();
        if1.release_all = 1'b0;
        mapw(9'h120, 8'hE3);
        strobe(9'h033, 1'b1);
        strobe(9'h120, 1'b1);
        tick(); tick();
        scan_all_clear("unmapped");

        // release_all meeting a press in S1
        goto_row(0);
        strobe(9'h01C, 1'b1);
        if1.release_all = 1'b1;
        tick();
        if1.release_all = 1'b0;
        tick(); tick();
        chk("relall_race", if1.reg_4017, 4'hF);

        // Reset with 20 keys held
        for (int i = 0; i < 20; i++) begin
            mapw(9'h040 + 9'(i), {1'b1, 4'(i % 9), 3'(i / 9)});
        end
        for (int i = 0; i < 20; i++) strobe(9'h040 + 9'(i), 1'b1);
        tick(); tick();
        goto_row(0);
        if1.reg_4016 = 3'b110;
        tick();
        chk("held20_row0", if1.reg_4017, 4'h8);
        chk("held20_row0_s0", if0.reg_4017, 4'h8);
        reset = 1'b1;
        tick();
        chk("mid_reset_4017", if1.reg_4017, 4'h0);
        chk("mid_reset_row", if1.cur_row, 4'd0);
        reset = 1'b0;
        scan_all_clear("after_reset");
        strobe(9'h01C, 1'b1);
        tick(); tick();
        goto_row(0);
        chk("map_kept", if1.reg_4017, 4'h7);

        // Randomized run against the model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ra[i] = 9'(i * 37);
            mapw(ra[i], {($urandom % 4) != 0, 4'($urandom % 12),
                         3'($urandom % 8)});
        end
        for (int t = 0; t < 4000; t++) begin
            if1.reg_4016 = {($urandom % 8) != 0, 1'($urandom % 2),
                            ($urandom % 40) == 0};
            if1.key_strobe   = ($urandom % 3) == 0;
            {if1.key_extended, if1.key_code} = ra[$urandom % 16];
            if1.key_pressed  = 1'($urandom % 2);
            if1.map_we       = ($urandom % 50) == 0;
            if1.map_addr     = ra[$urandom % 16];
            if1.map_data     = {($urandom % 4) != 0, 4'($urandom % 12),
                                3'($urandom % 8)};
            if1.release_all  = ($urandom % 100) == 0;
            reset            = ($urandom % 500) == 0;
            tick();
            chk("rand_out", if1.reg_4017, m_out);
            chk("rand_row", if1.cur_row, m_row);
        end
        reset = 1'b0;
        if1.key_strobe = 1'b0;
        if1.map_we = 1'b0;
        if1.release_all = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
